uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter SETTLE_TICKS, default 2: tx_clk ticks to wait after a baud_sel change before the frame starts; range 0-15.
REQ-002 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-003 clk_in  input  1  sole clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 tx_clk  input  1  one-cycle bit tick from the baud generator; one tick per bit period.
REQ-006 req0_valid, req1_valid  input  1 each  requester has a byte to send.
REQ-007 req0_data, req1_data  input  8 each  byte to send; must be stable while valid is high.
REQ-008 req0_baud, req1_baud  input  2 each  baud code wanted: 0=2400, 1=9600, 2=19200, 3=38400.
REQ-009 req0_ack, req1_ack  output  1 each  registered one-cycle pulse; the byte was captured on the preceding edge.
REQ-010 baud_sel  output  2  registered baud code driven to the baud generator.
REQ-011 tx  output  1  serial line; idle high.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 grant_id  output  1  requester of the current or most recent frame.

Function
REQ-014 The block SHALL use the states IDLE, SETTLE, ALIGN, START, DATA and STOP.
REQ-015 IDLE with any valid high: grant, capture the requester's data and baud, and pulse its ack in the next cycle; tx_clk is ignored in that cycle.
REQ-016 Arbitration: a single valid wins; if both are valid, the requester not equal to last_grant wins (round-robin); last_grant is updated on each grant.
REQ-017 If the captured baud differs from baud_sel: load baud_sel at the grant edge and enter SETTLE; if SETTLE_TICKS=0, go straight to ALIGN.
REQ-018 If the captured baud equals baud_sel: enter ALIGN; baud_sel is unchanged.
REQ-019 SETTLE counts tx_clk ticks with a 4-bit counter and enters ALIGN on tick number SETTLE_TICKS; tx stays 1.
REQ-020 ALIGN: on the next tx_clk, tx goes to 0 and the state becomes START.
REQ-021 START: on tx_clk, tx takes data bit 0, bit_cnt=0, and the state becomes DATA.
REQ-022 DATA: on each tx_clk with bit_cnt<7, tx takes the next bit (LSB first) and bit_cnt increments.
REQ-023 DATA: on tx_clk with bit_cnt=7, tx goes to 1 and the state becomes STOP.
REQ-024 STOP: after STOP_BITS further tx_clk ticks, the state returns to IDLE; tx stays 1.
REQ-025 Each line bit is held for exactly one tick interval; tx only changes on the edge that samples tx_clk=1.
REQ-026 A valid deasserted before its grant is dropped without effect.
REQ-027 A valid still high during its ack cycle is not re-granted, because the state is no longer IDLE.
REQ-028 A requester must present new data or drop valid within the ack cycle.
REQ-029 Back-to-back frames: IDLE may grant in the same cycle it is entered from STOP.
REQ-030 busy is registered and is high from the cycle after a grant until the cycle after STOP exits.

Reset
REQ-031 While rst=0 at an edge: state=IDLE, tx=1, baud_sel=2'd1, busy=0, acks=0, grant_id=0, last_grant=1, counters=0.
REQ-032 Reset mid-frame discards the captured byte; that requester's ack is not reasserted.

Verification
REQ-033 Reset: hold rst=0 for 2 edges with tx_clk pulsing -> tx=1, baud_sel=1, busy=0, both acks=0.
REQ-034 Byte 0xA5 on req0 with baud 1 -> req0_ack pulses one cycle; on successive ticks tx = 0, 1,0,1,0,0,1,0,1, then 1; busy falls after the stop tick.
REQ-035 Both valid after reset -> req0 served first (grant_id=0), then req1; a repeat with both valid alternates.
REQ-036 req1 with baud 3 while baud_sel=1 -> baud_sel=3 one cycle after the grant; tx=1 for 2 ticks plus the ALIGN tick before the start bit.
REQ-037 Reset during DATA bit 4 -> tx=1 and busy=0 on the next edge; no ack; the next request starts a fresh frame.
REQ-038 tx_clk=1 in the same cycle as a grant with equal baud -> that tick is ignored; the start bit begins on the following tick.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Two-requester UART transmit scheduler: round-robin grant, baud switch with settle
// delay, then an 8N1/8N2 frame clocked by the baud generator's bit tick.
module uart_tx_sched #(
    parameter int SETTLE_TICKS = 2,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tx_clk,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    input  logic [1:0] req0_baud,
    input  logic [1:0] req1_baud,
    output logic       req0_ack,
    output logic       req1_ack,
    output logic [1:0] baud_sel,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ALIGN  = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    localparam logic [3:0] SETTLE_N = 4'(SETTLE_TICKS);
    localparam logic [1:0] STOP_N   = 2'(STOP_BITS);

    state_t     state_r;
    logic [7:0] data_r;
    logic [3:0] settle_cnt_r;
    logic [2:0] bit_cnt_r;
    logic [1:0] stop_cnt_r;
    logic       last_grant_r;
    logic       tx_r;
    logic       busy_r;
    logic       ack0_r;
    logic       ack1_r;
    logic       grant_id_r;
    logic [1:0] baud_sel_r;

    logic       any_s;
    logic       win_s;
    logic [7:0] win_data_s;
    logic [1:0] win_baud_s;

    // Round-robin arbitration between the two requesters
    always_comb begin
        any_s      = req0_valid | req1_valid;
        win_s      = 1'b0;
        win_data_s = req0_data;
        win_baud_s = req0_baud;
        if (req0_valid && req1_valid) begin
            win_s = ~last_grant_r;
        end else if (req1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            win_data_s = req1_data;
            win_baud_s = req1_baud;
        end else begin
            win_data_s = req0_data;
            win_baud_s = req0_baud;
        end
    end

    // Frame sequencer; the grant cycle deliberately ignores tx_clk
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            data_r       <= 8'd0;
            settle_cnt_r <= 4'd0;
            bit_cnt_r    <= 3'd0;
            stop_cnt_r   <= 2'd0;
            last_grant_r <= 1'b1;
            tx_r         <= 1'b1;
            busy_r       <= 1'b0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            grant_id_r   <= 1'b0;
            baud_sel_r   <= 2'd1;
        end else begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (any_s) begin
                        grant_id_r   <= win_s;
                        last_grant_r <= win_s;
                        data_r       <= win_data_s;
                        ack0_r       <= ~win_s;
                        ack1_r       <= win_s;
                        busy_r       <= 1'b1;
                        settle_cnt_r <= 4'd0;
                        if (win_baud_s != baud_sel_r) begin
                            baud_sel_r <= win_baud_s;
                            if (SETTLE_N == 4'd0) begin
                                state_r <= S_ALIGN;
                            end else begin
                                state_r <= S_SETTLE;
                            end
                        end else begin
                            state_r <= S_ALIGN;
                        end
                    end
                end
                S_SETTLE: begin
                    if (tx_clk) begin
                        if (settle_cnt_r + 4'd1 == SETTLE_N) begin
                            state_r <= S_ALIGN;
                        end else begin
                            settle_cnt_r <= settle_cnt_r + 4'd1;
                        end
                    end
                end
                S_ALIGN: begin
                    if (tx_clk) begin
                        tx_r    <= 1'b0;
                        state_r <= S_START;
                    end
                end
                S_START: begin
                    if (tx_clk) begin
                        tx_r      <= data_r[0];
                        bit_cnt_r <= 3'd0;
                        state_r   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_clk) begin
                        if (bit_cnt_r == 3'd7) begin
                            tx_r       <= 1'b1;
                            stop_cnt_r <= 2'd0;
                            state_r    <= S_STOP;
                        end else begin
                            tx_r      <= data_r[bit_cnt_r + 3'd1];
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (tx_clk) begin
                        if (stop_cnt_r + 2'd1 == STOP_N) begin
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            stop_cnt_r <= stop_cnt_r + 2'd1;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ack = ack0_r;
    assign req1_ack = ack1_r;
    assign baud_sel = baud_sel_r;
    assign tx       = tx_r;
    assign busy     = busy_r;
    assign grant_id = grant_id_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a line-bit queue model checked every cycle plus
// directed scenarios with literal expectations.
module tb_uart_tx_sched;

    localparam int SETTLE = 2;
    localparam int STOPB  = 1;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       tx_clk;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic [1:0] req0_baud, req1_baud;
    logic       req0_ack, req1_ack;
    logic [1:0] baud_sel;
    logic       tx, busy, grant_id;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    uart_tx_sched #(.SETTLE_TICKS(SETTLE), .STOP_BITS(STOPB)) dut (
        .clk_in(clk_in), .rst(rst), .tx_clk(tx_clk),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_baud(req0_baud), .req1_baud(req1_baud),
        .req0_ack(req0_ack), .req1_ack(req1_ack),
        .baud_sel(baud_sel), .tx(tx), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is the list of values the line takes on successive ticks
    logic       m_tx, m_busy, m_ack0, m_ack1, m_gid, m_last;
    logic [1:0] m_baud;
    bit         mq[$];

    initial begin
        forever begin
            @(posedge clk_in);
            if (!rst) begin
                mq.delete();
                m_tx = 1'b1; m_busy = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0;
                m_gid = 1'b0; m_last = 1'b1; m_baud = 2'd1;
            end else begin
                m_ack0 = 1'b0;
                m_ack1 = 1'b0;
                if (!m_busy) begin
                    if (req0_valid || req1_valid) begin
                        logic       w;
                        logic [7:0] d;
                        logic [1:0] b;
                        w = (req0_valid && req1_valid) ? !m_last : req1_valid;
                        d = w ? req1_data : req0_data;
                        b = w ? req1_baud : req0_baud;
                        m_gid = w; m_last = w;
                        if (w) m_ack1 = 1'b1; else m_ack0 = 1'b1;
                        mq.delete();
                        if (b != m_baud) begin
                            m_baud = b;
                            for (int i = 0; i < SETTLE; i++) mq.push_back(1'b1);
                        end
                        mq.push_back(1'b0);
                        for (int i = 0; i < 8; i++) mq.push_back(d[i]);
                        for (int i = 0; i <= STOPB; i++) mq.push_back(1'b1);
                        m_busy = 1'b1;
                    end
                end else if (tx_clk) begin
                    m_tx = mq.pop_front();
                    if (mq.size() == 0) m_busy = 1'b0;
                end
            end
        end
    end

    // Compare every output against the model away from the active edge
    initial begin
        forever begin
            @(negedge clk_in);
            if (chk_en) begin
                chk("tx", tx, m_tx);
                chk("busy", busy, m_busy);
                chk("baud_sel", baud_sel, m_baud);
                chk("req0_ack", req0_ack, m_ack0);
                chk("req1_ack", req1_ack, m_ack1);
                chk("grant_id", grant_id, m_gid);
            end
        end
    end

    // Pulse tx_clk for one cycle, sample the result, then leave a gap cycle
    task automatic tick(output logic t, output logic b);
        tx_clk = 1'b1;
        @(negedge clk_in);
        t = tx;
        b = busy;
        tx_clk = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic run_until_idle(input int max);
        logic t, b;
        b = 1'b1;
        for (int i = 0; i < max; i++) begin
            tick(t, b);
            if (!b) break;
        end
        chk("idle_within_budget", b, 1'b0);
    endtask

    logic t, b;
    bit   exp_a5[10];

    initial begin
        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rst = 1'b0; tx_clk = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        req0_baud = 2'd0; req1_baud = 2'd0;

        // Reset for two edges with tx_clk pulsing
        @(negedge clk_in); tx_clk = 1'b1;
        @(negedge clk_in); tx_clk = 1'b0;
        chk("rst_tx", tx, 1'b1);
        chk("rst_baud", baud_sel, 2'd1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack0", req0_ack, 1'b0);
        chk("rst_ack1", req1_ack, 1'b0);
        chk_en = 1'b1;
        rst = 1'b1;
        @(negedge clk_in);

        // 0xA5 on req0 at the current baud
        req0_valid = 1'b1; req0_data = 8'hA5; req0_baud = 2'd1;
        @(negedge clk_in);
        chk("a5_ack0", req0_ack, 1'b1);
        req0_valid = 1'b0;
        @(negedge clk_in);
        chk("a5_ack0_one_cycle", req0_ack, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(t, b);
            chk($sformatf("a5_bit%0d", i), t, exp_a5[i]);
        end
        chk("a5_busy_in_stop", b, 1'b1);
        tick(t, b);
        chk("a5_busy_after_stop", b, 1'b0);

        // Round robin from reset
        rst = 1'b0; @(negedge clk_in); rst = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h11; req0_baud = 2'd1;
        req1_valid = 1'b1; req1_data = 8'h22; req1_baud = 2'd1;
        @(negedge clk_in);
        chk("rr1_gid", grant_id, 1'b0);
        chk("rr1_ack0", req0_ack, 1'b1);
        req0_valid = 1'b0;
        run_until_idle(20);
        chk("rr2_gid", grant_id, 1'b1);
        chk("rr2_ack1", req1_ack, 1'b1);
        req1_valid = 1'b0;
        run_until_idle(20);
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk_in);
        chk("rr3_gid", grant_id, 1'b0);
        req0_valid = 1'b0;
        run_until_idle(20);
        chk("rr4_gid", grant_id, 1'b1);
        req1_valid = 1'b0;
        run_until_idle(20);

        // Baud change on req1 with settle ticks
        req1_valid = 1'b1; req1_data = 8'h81; req1_baud = 2'd3;
        @(negedge clk_in);
        chk("baud_ack1", req1_ack, 1'b1);
        chk("baud_sel3", baud_sel, 2'd3);
        req1_valid = 1'b0;
        tick(t, b); chk("settle_t1", t, 1'b1);
        tick(t, b); chk("settle_t2", t, 1'b1);
        tick(t, b); chk("align_start", t, 1'b0);
        tick(t, b); chk("baud_bit0", t, 1'b1);
        run_until_idle(20);

        // Reset during data bit 4
        req0_valid = 1'b1; req0_data = 8'h0F; req0_baud = 2'd3;
        @(negedge clk_in);
        req0_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick(t, b);
        chk("mid_bit4", tx, 1'b0);
        rst = 1'b0; tx_clk = 1'b1;
        @(negedge clk_in);
        tx_clk = 1'b0;
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ack0", req0_ack, 1'b0);
        rst = 1'b1;
        @(negedge clk_in);
        req0_valid = 1'b1; req0_data = 8'h5A; req0_baud = 2'd1;
        @(negedge clk_in);
        chk("fresh_ack0", req0_ack, 1'b1);
        req0_valid = 1'b0;
        run_until_idle(20);

        // Tick coincident with the grant is ignored; stale request is dropped
        req0_valid = 1'b1; req0_data = 8'h3C; req0_baud = 2'd1; tx_clk = 1'b1;
        @(negedge clk_in);
        tx_clk = 1'b0;
        chk("coin_ack0", req0_ack, 1'b1);
        chk("coin_tx_idle", tx, 1'b1);
        req0_valid = 1'b0;
        tick(t, b); chk("coin_start", t, 1'b0);
        req1_valid = 1'b1;
        @(negedge clk_in); @(negedge clk_in);
        req1_valid = 1'b0;
        run_until_idle(20);
        repeat (4) @(negedge clk_in);
        chk("dropped_no_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
